// File: rtl/mealy_stream_recover.sv
// Tracks a 4-state Mealy encoder from its 3-bit code stream and recovers each input bit; 1-cycle latency, no backpressure.
// Optional MEALY_RECOVER_AUTO_RESYNC_EN: relock from LOST on any code that identifies its source state.
module mealy_stream_recover #(
  parameter int         CNT_W       = 8,
  parameter logic [1:0] START_STATE = 2'b00
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       code_in,
  input  logic             code_valid,
  input  logic             sync,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             ambiguous,
  output logic             err,
  output logic             lost,
  output logic [1:0]       state_q,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // LOST is encoded with the low bits zero so state_q reads 00 while lost.
  typedef enum logic [2:0] {
    ST_A    = 3'b000,
    ST_B    = 3'b001,
    ST_C    = 3'b010,
    ST_D    = 3'b011,
    ST_LOST = 3'b100
  } trk_e;

  typedef struct packed {
    logic legal;
    trk_e nxt;
    logic bit_v;
    logic amb;
  } dec_t;

  localparam trk_e START_TRK = trk_e'({1'b0, START_STATE});

  function automatic dec_t decode(input trk_e s, input logic [2:0] c);
    dec_t d;
    d = '{legal: 1'b0, nxt: ST_LOST, bit_v: 1'b0, amb: 1'b0};
    case (s)
      ST_A: begin
        if (c == 3'b111)      d = '{legal: 1'b1, nxt: ST_B, bit_v: 1'b0, amb: 1'b0};
        else if (c == 3'b101) d = '{legal: 1'b1, nxt: ST_C, bit_v: 1'b1, amb: 1'b0};
      end
      ST_B: begin
        if (c == 3'b001)      d = '{legal: 1'b1, nxt: ST_D, bit_v: 1'b0, amb: 1'b0};
        else if (c == 3'b011) d = '{legal: 1'b1, nxt: ST_A, bit_v: 1'b1, amb: 1'b0};
      end
      ST_C: begin
        if (c == 3'b000)      d = '{legal: 1'b1, nxt: ST_B, bit_v: 1'b0, amb: 1'b0};
        else if (c == 3'b100) d = '{legal: 1'b1, nxt: ST_D, bit_v: 1'b1, amb: 1'b0};
      end
      ST_D: begin
        if (c == 3'b110)      d = '{legal: 1'b1, nxt: ST_D, bit_v: 1'b0, amb: 1'b1};
      end
      default: ;
    endcase
    return d;
  endfunction

  trk_e             trk_q;
  logic             bit_out_q;
  logic             bit_valid_q;
  logic             amb_q;
  logic             err_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  dec_t             dec;

  always_comb begin
    dec = decode(trk_q, code_in);
  end

`ifdef MEALY_RECOVER_AUTO_RESYNC_EN
  dec_t rs;

  // Every legal code is emitted from exactly one state, so it pins down where the encoder was.
  always_comb begin
    rs = '{legal: 1'b0, nxt: ST_LOST, bit_v: 1'b0, amb: 1'b0};
    case (code_in)
      3'b111, 3'b101: rs = decode(ST_A, code_in);
      3'b001, 3'b011: rs = decode(ST_B, code_in);
      3'b000, 3'b100: rs = decode(ST_C, code_in);
      3'b110:         rs = decode(ST_D, code_in);
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trk_q       <= START_TRK;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      amb_q       <= 1'b0;
      err_q       <= 1'b0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      amb_q       <= 1'b0;
      err_q       <= 1'b0;
      if (sync) begin
        trk_q <= START_TRK;
      end else if (code_valid) begin
        if (trk_q == ST_LOST) begin
`ifdef MEALY_RECOVER_AUTO_RESYNC_EN
          if (rs.legal) trk_q <= rs.nxt;
`endif
        end else if (dec.legal) begin
          trk_q       <= dec.nxt;
          bit_out_q   <= dec.bit_v;
          amb_q       <= dec.amb;
          bit_valid_q <= 1'b1;
          if (bit_cnt_q != {CNT_W{1'b1}}) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end else begin
          trk_q <= ST_LOST;
          err_q <= 1'b1;
          if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign ambiguous = amb_q;
  assign err       = err_q;
  assign lost      = trk_q[2];
  assign state_q   = trk_q[1:0];
  assign bit_cnt   = bit_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
